// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the instruction-fetch path: word width, reset PC and fetch FSM states.
package cpu_pkg;

    localparam int unsigned      XLEN             = 32;
    localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    function automatic logic word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: the fetch unit is the master, the memory is the slave.
interface instr_fetch_if;
    import cpu_pkg::*;

    logic            mem_rd;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (output mem_rd, mem_addr, input mem_ready, mem_rdata);
    modport slave  (input mem_rd, mem_addr, output mem_ready, mem_rdata);

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-state counter for an outstanding fetch; expired flags the last permitted wait cycle.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= count + W'(1);
    end

    assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word read per fetch_req, captures the word into Instr
// and advances the PC; misaligned PCs and memory timeouts park the unit in a sticky fault.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [XLEN-1:0]   pc_in,
    instr_fetch_if.master     mem,
    output logic [XLEN-1:0]   Instr,
    output logic              IRWrite,
    output logic [XLEN-1:0]   pc_out,
    output logic              busy,
    output logic              fault
);

    fetch_state_e    state, state_nx;
    logic [XLEN-1:0] pc_nx, addr_nx, instr_nx, fetch_addr;
    logic            expired;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (CLK),
        .reset   (reset),
        .clear   (state != S_REQ),
        .enable  ((state == S_REQ) && !mem.mem_ready),
        .expired (expired)
    );

    // A branch target presented together with fetch_req is fetched in the same cycle.
    assign fetch_addr = pc_load ? pc_in : pc_out;

    always_comb begin
        state_nx = state;
        pc_nx    = pc_out;
        addr_nx  = mem.mem_addr;
        instr_nx = Instr;
        case (state)
            S_IDLE: begin
                if (pc_load)
                    pc_nx = pc_in;
                if (fetch_req) begin
                    if (word_aligned(fetch_addr)) begin
                        state_nx = S_REQ;
                        addr_nx  = fetch_addr;
                    end else begin
                        state_nx = S_FAULT;
                    end
                end
            end
            S_REQ: begin
                // A response on the final wait cycle still completes the fetch.
                if (mem.mem_ready) begin
                    state_nx = S_DONE;
                    instr_nx = mem.mem_rdata;
                    pc_nx    = pc_out + XLEN'(4);
                end else if (expired) begin
                    state_nx = S_FAULT;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_FAULT: begin
                if (pc_load) begin
                    pc_nx    = pc_in;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= S_IDLE;
            pc_out       <= RESET_PC;
            Instr        <= '0;
            IRWrite      <= 1'b0;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nx;
            pc_out       <= pc_nx;
            Instr        <= instr_nx;
            IRWrite      <= (state_nx == S_DONE);
            mem.mem_rd   <= (state_nx == S_REQ);
            mem.mem_addr <= addr_nx;
            busy         <= (state_nx == S_REQ) || (state_nx == S_DONE);
            fault        <= (state_nx == S_FAULT);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized fetch transactions checked against a transaction-level model of the fetch unit.
module tb_instr_fetch;

    localparam int unsigned TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [31:0] pc_in;
    logic [31:0] Instr;
    logic        IRWrite;
    logic [31:0] pc_out;
    logic        busy;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    // Model state: what the PC and instruction register should hold between transactions.
    logic [31:0] pc_model;
    logic [31:0] instr_model;

    instr_fetch_if mif ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .fetch_req (fetch_req),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .mem       (mif.master),
        .Instr     (Instr),
        .IRWrite   (IRWrite),
        .pc_out    (pc_out),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete fetch: launch, serve the memory after `waits` stall cycles, then compare the
    // observed transaction against what the rules predict.
    task automatic do_fetch(input bit load, input logic [31:0] tgt, input int waits,
                            input bit noise, input logic [31:0] data, input string tag);
        logic [31:0] addr;
        int          rd, irw, cyc;
        bit          addr_ok, aligned, ok;
        addr    = load ? tgt : pc_model;
        aligned = (addr[1:0] == 2'b00);
        ok      = aligned && (waits < int'(TIMEOUT));
        @(negedge CLK);
        fetch_req = 1'b1; pc_load = load; pc_in = tgt;
        @(negedge CLK);
        fetch_req = 1'b0; pc_load = 1'b0;
        rd = 0; irw = 0; cyc = 0; addr_ok = 1'b1;
        while (cyc < 40) begin
            if (mif.mem_rd) begin
                rd++;
                if (mif.mem_addr !== addr) addr_ok = 1'b0;
            end
            if (IRWrite) irw++;
            if (!busy) break;
            mif.mem_ready = mif.mem_rd && (rd == waits + 1);
            mif.mem_rdata = mif.mem_ready ? data : $urandom;
            if (noise) begin
                fetch_req = 1'($urandom); pc_load = 1'($urandom); pc_in = $urandom;
            end
            @(negedge CLK);
            cyc++;
        end
        mif.mem_ready = 1'b0; fetch_req = 1'b0; pc_load = 1'b0;

        if (ok) begin
            pc_model    = addr + 32'd4;
            instr_model = data;
        end else begin
            pc_model    = addr;
        end
        check({tag, "_bounded"}, 32'(cyc < 40), 32'd1);
        check({tag, "_rd_cycles"}, 32'(rd),
              !aligned ? 32'd0 : (ok ? 32'(waits + 1) : 32'(TIMEOUT)));
        check({tag, "_addr_stable"}, 32'(addr_ok), 32'd1);
        check({tag, "_irwrite_cnt"}, 32'(irw), 32'(ok));
        check({tag, "_instr"}, Instr, instr_model);
        check({tag, "_pc"}, pc_out, pc_model);
        check({tag, "_fault"}, 32'(fault), 32'(!ok));
        check({tag, "_mem_rd_end"}, 32'(mif.mem_rd), 32'd0);
    endtask

    // Fault must hold against a bare fetch_req and clear only on pc_load.
    task automatic recover(input logic [31:0] tgt);
        @(negedge CLK);
        fetch_req = 1'b1;
        @(negedge CLK);
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_no_rd", 32'(mif.mem_rd), 32'd0);
        pc_load = 1'b1; pc_in = tgt;
        @(negedge CLK);
        fetch_req = 1'b0; pc_load = 1'b0;
        pc_model = tgt;
        check("recover_fault", 32'(fault), 32'd0);
        check("recover_pc", pc_out, tgt);
        check("recover_busy", 32'(busy), 32'd0);
        check("recover_rd", 32'(mif.mem_rd), 32'd0);
    endtask

    task automatic idle_ready();
        @(negedge CLK);
        mif.mem_ready = 1'b1; mif.mem_rdata = $urandom;
        @(negedge CLK);
        mif.mem_ready = 1'b0;
        check("idle_ready_irw", 32'(IRWrite), 32'd0);
        check("idle_ready_busy", 32'(busy), 32'd0);
        check("idle_ready_instr", Instr, instr_model);
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_in = '0;
        mif.mem_ready = 1'b0; mif.mem_rdata = '0;
        pc_model = 32'h0; instr_model = 32'h0;
        repeat (2) @(negedge CLK);
        check("rst_pc", pc_out, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_irw", 32'(IRWrite), 32'd0);
        check("rst_rd", 32'(mif.mem_rd), 32'd0);
        check("rst_addr", mif.mem_addr, 32'h0);
        check("rst_flags", {30'd0, busy, fault}, 32'd0);
        reset = 1'b0;

        do_fetch(1'b0, 32'h0, 0, 1'b0, 32'h8C22_0004, "basic");
        check("basic_word", Instr, 32'h8C22_0004);
        check("basic_pc4", pc_out, 32'h4);
        do_fetch(1'b0, 32'h0, 3, 1'b0, $urandom, "wait3");
        do_fetch(1'b0, 32'h0, 100, 1'b0, $urandom, "timeout");
        recover(32'h100);
        do_fetch(1'b1, 32'h102, 0, 1'b0, $urandom, "misalign");
        recover(32'h200);
        do_fetch(1'b0, 32'h0, int'(TIMEOUT) - 1, 1'b0, $urandom, "last_wait");
        do_fetch(1'b0, 32'h0, 2, 1'b1, $urandom, "noise");
        do_fetch(1'b1, 32'hFFFF_FFFC, 1, 1'b0, $urandom, "wrap");
        check("wrap_zero", pc_out, 32'h0);
        do_fetch(1'b1, 32'h40, 0, 1'b0, $urandom, "load_fetch");
        idle_ready();

        // Reset in the middle of an outstanding read; the late response must be dropped.
        @(negedge CLK); fetch_req = 1'b1;
        @(negedge CLK); fetch_req = 1'b0;
        check("mid_req_rd", 32'(mif.mem_rd), 32'd1);
        @(negedge CLK); reset = 1'b1;
        @(negedge CLK); reset = 1'b0;
        pc_model = 32'h0; instr_model = 32'h0;
        check("midrst_rd", 32'(mif.mem_rd), 32'd0);
        check("midrst_pc", pc_out, 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
        @(negedge CLK); mif.mem_ready = 1'b0;
        check("late_ready_irw", 32'(IRWrite), 32'd0);
        check("late_ready_instr", Instr, 32'h0);
        @(negedge CLK);
        check("late_ready_irw2", 32'(IRWrite), 32'd0);

        for (int i = 0; i < 30; i++) begin
            bit          ld;
            logic [31:0] tgt;
            int          w;
            ld  = ($urandom_range(0, 2) == 0);
            tgt = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00, 2'b00};
            if (ld && $urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            w = ($urandom_range(0, 5) == 0) ? $urandom_range(int'(TIMEOUT) - 1, int'(TIMEOUT) + 1)
                                            : $urandom_range(0, 5);
            do_fetch(ld, tgt, w, 1'($urandom), $urandom, "rand");
            if (fault) recover({$urandom_range(0, 32'h0FFF_FFFF), 4'h0});
            if ($urandom_range(0, 3) == 0) idle_ready();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
